// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with occupancy FSM, threshold flags and error reporting.
// Define PARAM_FIFO_STICKY_ERR_EN to hold overflow/underflow high until reset instead of pulsing them.
module param_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_TOP  = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] AF_LEVEL = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LEVEL = (ADDR_WIDTH+1)'(AE_THRESH);

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic is_empty, is_full;
  logic wr_accept, rd_accept;
  logic ovf_evt, unf_evt;

  assign is_empty = (state_q == S_EMPTY);
  assign is_full  = (state_q == S_FULL);

  // A write while full is still taken when a same-cycle read frees a slot;
  // a read while empty is never served from the incoming write.
  always_comb begin
    rd_accept = read && !is_empty;
    wr_accept = write && (!is_full || rd_accept);
    ovf_evt   = write && is_full && !read;
    unf_evt   = read && is_empty && !write;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rdata_d     = rdata_q;
    rd_valid_d  = rd_accept;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      rdata_d  = mem_q[rd_ptr_q];
    end
    if (wr_accept && !rd_accept)      count_d = count_q + 1'b1;
    else if (rd_accept && !wr_accept) count_d = count_q - 1'b1;
`ifdef PARAM_FIFO_STICKY_ERR_EN
    overflow_d  = overflow_q | ovf_evt;
    underflow_d = underflow_q | unf_evt;
`else
    overflow_d  = ovf_evt;
    underflow_d = unf_evt;
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY:   if (wr_accept) state_d = S_PARTIAL;
      S_PARTIAL: begin
        if (wr_accept && !rd_accept && count_q == CNT_TOP)      state_d = S_FULL;
        else if (rd_accept && !wr_accept && count_q == CNT_ONE) state_d = S_EMPTY;
      end
      S_FULL:    if (rd_accept && !wr_accept) state_d = S_PARTIAL;
      default:   state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage has no reset; contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata        = rdata_q;
  assign rd_valid     = rd_valid_q;
  assign empty        = is_empty;
  assign full         = is_full;
  assign count        = count_q;
  assign almost_full  = (count_q >= AF_LEVEL);
  assign almost_empty = (count_q <= AE_LEVEL);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo: directed vector table, then random traffic against a queue model.
module tb_param_fifo;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;
  localparam int AF = 3;
  localparam int AE = 1;
`ifdef PARAM_FIFO_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, write, read;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          rd_valid, empty, full, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  int checks = 0;
  int errors = 0;

  param_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .reset(reset), .write(write), .wdata(wdata), .read(read),
    .rdata(rdata), .rd_valid(rd_valid), .empty(empty), .full(full),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          wr;
    logic [DW-1:0] wd;
    logic          rd;
    int            cnt;
    logic          rv;
    logic [DW-1:0] rdat;
    logic          ov;
    logic          un;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic wr, logic [DW-1:0] wd, logic rd,
                              int cnt, logic rv, logic [DW-1:0] rdat, logic ov, logic un);
    vec_t v;
    v.rst = rst; v.wr = wr; v.wd = wd; v.rd = rd; v.cnt = cnt;
    v.rv = rv; v.rdat = rdat; v.ov = ov; v.un = un;
    return v;
  endfunction

  // Drive one cycle of inputs, then let the edge happen and settle before sampling.
  task automatic applyStimulus(input logic rst, input logic wr, input logic [DW-1:0] wd, input logic rd);
    reset = rst; write = wr; wdata = wd; read = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int step, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, step, got, exp);
    end
  endtask

  task automatic checkAll(input int step, input int cnt, input logic rv, input logic [DW-1:0] rdat,
                          input logic ov, input logic un);
    checkOutput("count", step, 32'(count), 32'(cnt));
    checkOutput("empty", step, 32'(empty), 32'(cnt == 0));
    checkOutput("full", step, 32'(full), 32'(cnt == DEPTH));
    checkOutput("almost_full", step, 32'(almost_full), 32'(cnt >= AF));
    checkOutput("almost_empty", step, 32'(almost_empty), 32'(cnt <= AE));
    checkOutput("rd_valid", step, 32'(rd_valid), 32'(rv));
    checkOutput("rdata", step, 32'(rdata), 32'(rdat));
    checkOutput("overflow", step, 32'(overflow), 32'(ov));
    checkOutput("underflow", step, 32'(underflow), 32'(un));
  endtask

  initial begin
    logic seen_ov, seen_un;
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] m_rdata;
    logic m_rv, m_ov, m_un;
    logic r_rst, r_wr, r_rd;
    logic [DW-1:0] r_wd;
    logic rd_ok, wr_ok;

    reset = 1'b1; write = 1'b0; read = 1'b0; wdata = '0;

    // rst wr wd rd | cnt rv rdata ov un
    vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 8'h11, 0, 1, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 8'h22, 0, 2, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 8'h33, 0, 3, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 8'h44, 0, 4, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 8'h55, 0, 4, 0, 8'h00, 1, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 4, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 3, 1, 8'h11, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 2, 1, 8'h22, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h33, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h44, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h44, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h44, 0, 0));
    vecs.push_back(mk(0, 1, 8'hAA, 0, 1, 0, 8'h44, 0, 0));
    vecs.push_back(mk(0, 1, 8'hBB, 0, 2, 0, 8'h44, 0, 0));
    vecs.push_back(mk(0, 1, 8'hC0, 1, 2, 1, 8'hAA, 0, 0));
    vecs.push_back(mk(0, 1, 8'hC1, 1, 2, 1, 8'hBB, 0, 0));
    vecs.push_back(mk(0, 1, 8'hC2, 1, 2, 1, 8'hC0, 0, 0));
    vecs.push_back(mk(0, 1, 8'hC3, 1, 2, 1, 8'hC1, 0, 0));
    vecs.push_back(mk(0, 1, 8'hC4, 1, 2, 1, 8'hC2, 0, 0));
    vecs.push_back(mk(0, 1, 8'hC5, 1, 2, 1, 8'hC3, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'hC4, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'hC5, 0, 0));
    vecs.push_back(mk(0, 1, 8'h11, 0, 1, 0, 8'hC5, 0, 0));
    vecs.push_back(mk(0, 1, 8'h22, 0, 2, 0, 8'hC5, 0, 0));
    vecs.push_back(mk(0, 1, 8'h33, 0, 3, 0, 8'hC5, 0, 0));
    vecs.push_back(mk(0, 1, 8'h44, 0, 4, 0, 8'hC5, 0, 0));
    vecs.push_back(mk(0, 1, 8'h99, 1, 4, 1, 8'h11, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 3, 1, 8'h22, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 2, 1, 8'h33, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h44, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h99, 0, 0));
    vecs.push_back(mk(0, 1, 8'h77, 1, 1, 0, 8'h99, 0, 0));
    vecs.push_back(mk(0, 1, 8'h88, 0, 2, 0, 8'h99, 0, 0));
    vecs.push_back(mk(0, 1, 8'h66, 0, 3, 0, 8'h99, 0, 0));
    vecs.push_back(mk(1, 1, 8'h5A, 1, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));

    $display("[TB] directed phase: %0d vectors, sticky=%0d", vecs.size(), STICKY);
    seen_ov = 1'b0;
    seen_un = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].wd, vecs[i].rd);
      if (vecs[i].rst) begin
        seen_ov = 1'b0;
        seen_un = 1'b0;
      end else begin
        seen_ov = seen_ov | vecs[i].ov;
        seen_un = seen_un | vecs[i].un;
      end
      checkAll(i, vecs[i].cnt, vecs[i].rv, vecs[i].rdat,
               STICKY ? seen_ov : vecs[i].ov, STICKY ? seen_un : vecs[i].un);
    end

    // Random traffic: the model is a plain queue of words plus the acceptance rules.
    $display("[TB] random phase");
    applyStimulus(1'b1, 1'b0, '0, 1'b0);
    model_q.delete();
    m_rdata = '0; m_ov = 1'b0; m_un = 1'b0;
    for (int i = 0; i < 400; i++) begin
      r_rst = ($urandom_range(0, 99) == 0);
      r_wr  = ($urandom_range(0, 99) < 55);
      r_rd  = ($urandom_range(0, 99) < 50);
      r_wd  = DW'($urandom);
      applyStimulus(r_rst, r_wr, r_wd, r_rd);
      if (r_rst) begin
        model_q.delete();
        m_rdata = '0; m_rv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
      end else begin
        rd_ok = r_rd && (model_q.size() > 0);
        wr_ok = r_wr && ((model_q.size() < DEPTH) || rd_ok);
        if (STICKY) begin
          m_ov = m_ov | (r_wr && !wr_ok);
          m_un = m_un | (r_rd && !rd_ok && !r_wr);
        end else begin
          m_ov = r_wr && !wr_ok;
          m_un = r_rd && !rd_ok && !r_wr;
        end
        m_rv = rd_ok;
        if (rd_ok) m_rdata = model_q.pop_front();
        if (wr_ok) model_q.push_back(r_wd);
      end
      checkAll(1000 + i, model_q.size(), m_rv, m_rdata, m_ov, m_un);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
